i2c_master_core: RTL and testbench
==================================

# i2c_master_core

Bit-level I2C master engine that sits directly upstream of `i2c_slave` on the serial side. It turns one-byte commands from the APB register side into SCL/SDA waveforms: START or repeated START, 7-bit address plus R/W, ACK check, one data byte, then STOP or bus hold. It also generates the `repeated_start_cond` qualifier that `i2c_slave` consumes.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period. Minimum 1. One bit slot is 4·CLK_DIV cycles.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high when a command can be accepted; accepted on `cmd_valid && cmd_ready`.
- `cmd_addr`  in  7  slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_wdata`  in  8  write byte.
- `cmd_hold`  in  1  1 = end without STOP and keep the bus for a repeated START.
- `rx_data`  out  8  read byte; valid from the `done` pulse until the next read completes.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  set together with `done` when a NACK is seen; cleared on the next acceptance.
- `busy`  out  1  high from acceptance until `done`, and throughout HOLD.
- `repeated_start_cond`  out  1  one-cycle pulse at the start of a repeated-START slot.
- `scl_out`  out  1  SCL drive (1 = released/high).
- `sda_out`  out  1  SDA drive (1 = released).
- `sda_in`  in  1  sampled SDA.

## Operation
- Command fields are latched on acceptance; later changes on the inputs are ignored.
- Each bit slot has quarters Q0–Q3:
  - Data bits: SCL low in Q0 and Q1, high in Q2 and Q3.
  - `sda_out` updates on entry to Q0.
  - `sda_in` is sampled on the first clk of Q3.
- States: IDLE, START, RSTART, ADDR, AACK, WR, WACK, RD, RACK, STOP, HOLD.
- IDLE: `scl_out`=1, `sda_out`=1, `cmd_ready`=1. On accept → START.
- START: SCL=1 in all quarters; SDA=1 in Q0–Q1, SDA=0 in Q2–Q3. → ADDR.
- RSTART (entered from HOLD on accept):
  - Q0: SCL=0, SDA=1. Q1: SCL=1, SDA=1. Q2–Q3: SCL=1, SDA=0.
  - `repeated_start_cond` pulses on the first clk of Q0. → ADDR.
- ADDR: 8 slots, MSB first, shifting `{cmd_addr, cmd_rw}`. → AACK.
- AACK: SDA released. If sampled 1 → `ack_err`, go to STOP. Otherwise → WR when rw=0, RD when rw=1.
- WR: 8 slots, `cmd_wdata` MSB first. → WACK.
- WACK: SDA released. If sampled 1 → `ack_err`, go to STOP. Otherwise → STOP, or → HOLD if `cmd_hold`.
- RD: SDA released for 8 slots; shift in `sda_in` MSB first. → RACK.
- RACK: master drives NACK (SDA=1). Load `rx_data`. → STOP, or → HOLD if `cmd_hold`.
- STOP: SCL=0, SDA=0 in Q0–Q1; SCL=1, SDA=0 in Q2; SCL=1, SDA=1 in Q3. → IDLE.
- HOLD: `scl_out`=0, `sda_out`=1, `busy`=1, `cmd_ready`=1.
- A NACK always ends with STOP, even when `cmd_hold`=1.
- Counters:
  - Quarter counter `0..CLK_DIV-1` (width `$clog2(CLK_DIV)`, minimum 1).
  - 2-bit quarter index.
  - 3-bit bit index that wraps 7→0 into the ACK slot.

## Timing
- Reset values: `scl_out`=1, `sda_out`=1, `cmd_ready`=1, `busy`=0, `done`=0, `ack_err`=0, `repeated_start_cond`=0, `rx_data`=8'h00. Internal state is IDLE.
- Reset asserted mid-transfer: on the next edge, return to reset values and IDLE. No STOP is generated.
- The first slot starts on the clk after acceptance. `cmd_ready` and `busy` update on the same edge.
- Slot counts, from acceptance to `done`:
  - Full transaction with STOP: 20 slots = 80·CLK_DIV cycles. `done` pulses on the cycle after STOP Q3 ends.
  - Address NACK: 11 slots (START, ADDR, AACK, STOP).
  - Hold ending: 19 slots. `done` pulses on the first HOLD cycle.
- `cmd_ready` returns to 1 in the same cycle as `done`.
- `cmd_valid` while `cmd_ready`=0 is ignored; no queuing.
- Acceptance in the same cycle as `done`: legal. The next transaction starts on the following cycle.

## Test plan
- Write, CLK_DIV=2, addr=0x2A, wdata=0x55, bench ACKs → SDA bytes 0x54 then 0x55; STOP present; `done` 160 cycles after acceptance; `ack_err`=0.
- Address NACK (bench leaves SDA high) → STOP right after AACK; `done` at 11 slots; `ack_err`=1; no data slots.
- Read, addr=0x2A, rw=1, bench drives 0xA5 → `rx_data`=0xA5; SDA=1 in RACK; STOP; `ack_err`=0.
- Write with `cmd_hold`=1, then read command → no STOP between them; SCL low in HOLD; `repeated_start_cond` pulses exactly once; second address byte 0x55.
- `rst_n` low for one clk during ADDR bit 3 → next edge gives `scl_out`=1, `sda_out`=1, `busy`=0, `cmd_ready`=1; a new command then runs normally.
- `cmd_valid` held high during a busy write → exactly one transaction; the second command is accepted on the `done` cycle and completes correctly.

Source files
------------

// File: rtl/i2c_master_core.sv
// Bit-level I2C master: one command = START/RSTART, address+R/W, ACK, one data byte,
// then STOP or bus hold for a repeated START.
module i2c_master_core #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_hold,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  output logic       repeated_start_cond,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, RSTART, ADDR, AACK, WR, WACK, RD, RACK, STOP, HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [1:0]    quarter, quarter_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [6:0]    addr_r;
  logic          rw_r;
  logic [7:0]    wdata_r;
  logic          hold_r;
  logic [7:0]    rx_shift;
  logic          nack_r;
  logic          err_pend;
  logic          accept;
  logic          sample_pt;
  logic          slot_end;
  logic          ack_bit;
  logic [1:0]    drv;

  // Line levels {scl, sda} for a given slot position; outputs are registered from the
  // next-state position so they change exactly on quarter entry.
  function automatic logic [1:0] line_drive(state_t st, logic [1:0] q, logic [2:0] b,
                                            logic [7:0] abyte, logic [7:0] wbyte);
    logic [1:0] d;
    d = 2'b11;
    case (st)
      IDLE:    d = 2'b11;
      HOLD:    d = 2'b01;
      START:   d = {1'b1, ~q[1]};
      RSTART:  d = {q != 2'd0, ~q[1]};
      ADDR:    d = {q[1], abyte[~b]};
      WR:      d = {q[1], wbyte[~b]};
      STOP:    d = {q[1], q == 2'd3};
      default: d = {q[1], 1'b1};
    endcase
    return d;
  endfunction

  always_comb begin
    accept      = cmd_valid && cmd_ready;
    sample_pt   = (quarter == 2'd3) && (qcnt == '0);
    slot_end    = (quarter == 2'd3) && (qcnt == QMAX);
    // With CLK_DIV=1 the sample clk is also the last clk of the slot.
    ack_bit     = sample_pt ? sda_in : nack_r;
    state_nxt   = state;
    quarter_nxt = quarter;
    qcnt_nxt    = qcnt;
    bit_idx_nxt = bit_idx;
    if (state == IDLE || state == HOLD) begin
      if (accept) begin
        state_nxt   = (state == IDLE) ? START : RSTART;
        quarter_nxt = '0;
        qcnt_nxt    = '0;
        bit_idx_nxt = '0;
      end
    end else begin
      qcnt_nxt = (qcnt == QMAX) ? '0 : qcnt + QW'(1);
      if (qcnt == QMAX)
        quarter_nxt = quarter + 2'd1;
      if (slot_end) begin
        case (state)
          START, RSTART: state_nxt = ADDR;
          ADDR: begin
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = AACK;
          end
          AACK: state_nxt = ack_bit ? STOP : (rw_r ? RD : WR);
          WR: begin
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = WACK;
          end
          WACK: state_nxt = (ack_bit || !hold_r) ? STOP : HOLD;
          RD: begin
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = RACK;
          end
          RACK:    state_nxt = hold_r ? HOLD : STOP;
          STOP:    state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
    drv = line_drive(state_nxt, quarter_nxt, bit_idx_nxt, {addr_r, rw_r}, wdata_r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      quarter             <= '0;
      qcnt                <= '0;
      bit_idx             <= '0;
      scl_out             <= 1'b1;
      sda_out             <= 1'b1;
      cmd_ready           <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
      ack_err             <= 1'b0;
      repeated_start_cond <= 1'b0;
      rx_data             <= 8'h00;
      err_pend            <= 1'b0;
    end else begin
      state               <= state_nxt;
      quarter             <= quarter_nxt;
      qcnt                <= qcnt_nxt;
      bit_idx             <= bit_idx_nxt;
      {scl_out, sda_out}  <= drv;
      cmd_ready           <= (state_nxt == IDLE) || (state_nxt == HOLD);
      busy                <= (state_nxt != IDLE);
      done                <= slot_end && (state != HOLD) &&
                             ((state == STOP) || (state_nxt == HOLD));
      repeated_start_cond <= accept && (state == HOLD);
      if (accept) begin
        ack_err  <= 1'b0;
        err_pend <= 1'b0;
      end else if (slot_end && (state == AACK || state == WACK) && ack_bit) begin
        err_pend <= 1'b1;
      end
      if (slot_end && state == STOP)
        ack_err <= err_pend;
      if (slot_end && state == RACK)
        rx_data <= rx_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r  <= cmd_addr;
      rw_r    <= cmd_rw;
      wdata_r <= cmd_wdata;
      hold_r  <= cmd_hold;
    end
    if (sample_pt && state == RD)
      rx_shift <= {rx_shift[6:0], sda_in};
    if (sample_pt)
      nack_r <= sda_in;
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: a bus monitor decodes START/STOP/bits from the lines, a
// slave model answers on SDA, and a transaction-level model predicts each outcome.
module tb_i2c_master_core;

  localparam int CLK_DIV = 2;
  localparam int SLOT    = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_hold = 1'b0;
  logic [7:0] rx_data;
  logic       done;
  logic       ack_err;
  logic       busy;
  logic       repeated_start_cond;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in = 1'b1;

  int checks = 0;
  int errors = 0;

  int   start_cnt = 0, stop_cnt = 0, rsc_cnt = 0, acc_cnt = 0, rise_cnt = 0;
  int   snap_start = 0, snap_stop = 0, snap_rsc = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic bitq[$];

  logic       s_rw = 1'b0, s_ack_addr = 1'b1, s_ack_data = 1'b1;
  logic [7:0] s_rdata = 8'h00;

  logic [7:0] rx_model = 8'h00;
  logic       in_hold = 1'b0;

  i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .cmd_hold(cmd_hold),
    .rx_data(rx_data), .done(done), .ack_err(ack_err), .busy(busy),
    .repeated_start_cond(repeated_start_cond), .scl_out(scl_out), .sda_out(sda_out),
    .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Slave answer for the n-th clocked bit after a START.
  function automatic logic slave_bit(int n);
    if (n == 8) return !s_ack_addr;
    if (!s_ack_addr) return 1'b1;
    if (n >= 9 && n <= 16) return s_rw ? s_rdata[3'(16 - n)] : 1'b1;
    if (n == 17) return s_rw ? 1'b1 : !s_ack_data;
    return 1'b1;
  endfunction

  always @(posedge clk)
    if (rst_n && cmd_valid && cmd_ready) acc_cnt++;

  always @(negedge clk) begin
    if (repeated_start_cond === 1'b1) rsc_cnt++;
    if (prev_scl && scl_out && prev_sda && !sda_out) begin
      start_cnt++;
      bitq.delete();
      rise_cnt = 0;
      sda_in = 1'b1;
    end else if (prev_scl && scl_out && !prev_sda && sda_out) begin
      stop_cnt++;
    end else if (!prev_scl && scl_out) begin
      bitq.push_back(sda_out);
      rise_cnt++;
    end else if (prev_scl && !scl_out) begin
      sda_in = slave_bit(rise_cnt);
    end
    prev_scl = scl_out;
    prev_sda = sda_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w, input logic h);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_addr = a; cmd_rw = r; cmd_wdata = w; cmd_hold = h; cmd_valid = 1'b1;
    @(posedge clk);
    snap_start = start_cnt; snap_stop = stop_cnt; snap_rsc = rsc_cnt;
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 7'($urandom);
    cmd_rw    = 1'($urandom);
    cmd_wdata = 8'($urandom);
    cmd_hold  = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (done !== 1'b1 && lat < 4000);
  endtask

  // Predict the outcome of one command from the slave's behaviour and compare.
  task automatic check_result(input string tag, input logic [6:0] a, input logic r,
                              input logic [7:0] w, input logic h, input int lat);
    logic nack, to_hold;
    int   slots, nbits;
    logic [7:0] abyte, dbyte;
    nack    = !s_ack_addr || (!r && !s_ack_data);
    to_hold = !nack && h;
    slots   = !s_ack_addr ? 11 : (to_hold ? 19 : 20);
    nbits   = !s_ack_addr ? 10 : (to_hold ? 18 : 19);
    if (r && s_ack_addr) rx_model = s_rdata;
    abyte = 8'h00;
    dbyte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < bitq.size()) abyte = {abyte[6:0], bitq[i]};
      if (i + 9 < bitq.size()) dbyte = {dbyte[6:0], bitq[i + 9]};
    end
    check({tag, "_latency"}, 32'(lat), 32'(slots * SLOT));
    check({tag, "_ack_err"}, 32'(ack_err), 32'(nack));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(rx_model));
    check({tag, "_addr_byte"}, 32'(abyte), 32'({a, r}));
    check({tag, "_bit_count"}, 32'(bitq.size()), 32'(nbits));
    check({tag, "_aack_released"}, 32'((bitq.size() > 8) ? bitq[8] : 1'b0), 32'd1);
    if (s_ack_addr) begin
      check({tag, "_data_byte"}, 32'(dbyte), r ? 32'hFF : 32'(w));
      check({tag, "_dack_sda"}, 32'((bitq.size() > 17) ? bitq[17] : 1'b0), 32'd1);
    end
    check({tag, "_stops"}, 32'(stop_cnt - snap_stop), to_hold ? 32'd0 : 32'd1);
    check({tag, "_starts"}, 32'(start_cnt - snap_start), 32'd1);
    check({tag, "_rsc"}, 32'(rsc_cnt - snap_rsc), 32'(in_hold));
    check({tag, "_busy"}, 32'(busy), 32'(to_hold));
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    if (to_hold) check({tag, "_hold_lines"}, 32'({scl_out, sda_out}), 32'b01);
    in_hold = to_hold;
  endtask

  task automatic run_cmd(input string tag, input logic [6:0] a, input logic r,
                         input logic [7:0] w, input logic h, input logic aa,
                         input logic ad, input logic [7:0] rd);
    int lat;
    s_rw = r; s_ack_addr = aa; s_ack_data = ad; s_rdata = rd;
    issue(a, r, w, h);
    check({tag, "_busy_start"}, 32'({busy, cmd_ready}), 32'b10);
    wait_done(lat);
    check_result(tag, a, r, w, h, lat);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, a0, sp0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl_out), 32'd1);
    check("rst_sda", 32'(sda_out), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rsc", 32'(repeated_start_cond), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd("wr", 7'h2A, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00);
    run_cmd("addr_nack", 7'h2A, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    run_cmd("rd", 7'h2A, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5);

    // Hold, stay parked, then repeated START into a read
    run_cmd("hold_wr", 7'h2A, 1'b0, 8'h96, 1'b1, 1'b1, 1'b1, 8'h00);
    sp0 = stop_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("hold_parked_lines", 32'({scl_out, sda_out, busy, cmd_ready}), 32'b0111);
    check("hold_no_stop", 32'(stop_cnt - sp0), 32'd0);
    run_cmd("rstart_rd", 7'h2A, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A);

    // Reset asserted for one clk during ADDR bit 3
    s_rw = 1'b0; s_ack_addr = 1'b1; s_ack_data = 1'b1;
    issue(7'h33, 1'b0, 8'hF0, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    sp0 = stop_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_lines", 32'({scl_out, sda_out}), 32'b11);
    check("mid_rst_ctl", 32'({busy, cmd_ready, done}), 32'b010);
    check("mid_rst_rx", 32'(rx_data), 32'h00);
    rx_model = 8'h00;
    in_hold  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_stop", 32'(stop_cnt - sp0), 32'd0);
    run_cmd("after_rst", 7'h19, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00);

    // cmd_valid held high while busy: second command taken on the done cycle
    s_rw = 1'b0; s_ack_addr = 1'b1; s_ack_data = 1'b1;
    @(negedge clk);
    a0 = acc_cnt;
    cmd_addr = 7'h11; cmd_rw = 1'b0; cmd_wdata = 8'hC3; cmd_hold = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    snap_start = start_cnt; snap_stop = stop_cnt; snap_rsc = rsc_cnt;
    #1;
    cmd_addr = 7'h2A; cmd_rw = 1'b1; cmd_wdata = 8'h00; cmd_hold = 1'b0;
    wait_done(lat);
    check_result("held_wr", 7'h11, 1'b0, 8'hC3, 1'b0, lat);
    check("held_wr_accepts", 32'(acc_cnt - a0), 32'd1);
    s_rw = 1'b1; s_rdata = 8'h3C;
    @(posedge clk);
    snap_start = start_cnt; snap_stop = stop_cnt; snap_rsc = rsc_cnt;
    #1;
    cmd_valid = 1'b0;
    check("held_rd_accepts", 32'(acc_cnt - a0), 32'd2);
    check("held_rd_busy", 32'({busy, cmd_ready, done}), 32'b100);
    wait_done(lat);
    check_result("held_rd", 7'h2A, 1'b1, 8'h00, 1'b0, lat);

    // Randomized commands against the transaction model
    for (int i = 0; i < 10; i++) begin
      run_cmd($sformatf("rnd%0d", i), 7'($urandom), 1'($urandom), 8'($urandom),
              1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
